// File: rtl/imm_extend_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module : imm_ext_pkg
// Desc   : Mode codes and mode width for the pipelined immediate extender.
// Rev    : 1.0  initial release
// ============================================================================
package imm_ext_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_SIGN  = 3'b000;
    localparam logic [MODE_W-1:0] MODE_ZERO  = 3'b001;
    localparam logic [MODE_W-1:0] MODE_UPPER = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHL2  = 3'b011;
    localparam logic [MODE_W-1:0] MODE_SBYTE = 3'b100;
    localparam logic [MODE_W-1:0] MODE_ZBYTE = 3'b101;

endpackage : imm_ext_pkg
`default_nettype wire

// File: rtl/imm_extend_pipe_if.sv
`default_nettype none
// ============================================================================
// Module : imm_extend_pipe_if
// Desc   : Input/output valid-ready bundle of the immediate extender.
// Rev    : 1.0  initial release
// ============================================================================
interface imm_extend_pipe_if
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_imm;
    logic [MODE_W-1:0] in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_err;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err
    );
endinterface : imm_extend_pipe_if
`default_nettype wire

// File: rtl/imm_extend_pipe_skid.sv
`default_nettype none
// ============================================================================
// Module : ext_skid_buffer
// Desc   : Two-entry (output + skid) valid/ready buffer, strict FIFO order.
// Rev    : 1.0  initial release
// ============================================================================
module ext_skid_buffer #(
    parameter int W = 33
) (
    input  wire logic         Clk,
    input  wire logic         Reset,
    input  wire logic         in_valid_i,
    output logic              in_ready_o,
    input  wire logic [W-1:0] in_data_i,
    output logic              out_valid_o,
    input  wire logic         out_ready_i,
    output logic [W-1:0]      out_data_o
);
    logic         o_valid_q, o_valid_d;
    logic [W-1:0] o_data_q,  o_data_d;
    logic         s_valid_q, s_valid_d;
    logic [W-1:0] s_data_q,  s_data_d;
    logic         in_ready_q, in_ready_d;
    logic         w_in_fire;
    logic         w_out_fire;

    assign w_in_fire  = in_valid_i && in_ready_q;
    assign w_out_fire = o_valid_q && out_ready_i;

    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        s_valid_d = s_valid_q;
        s_data_d  = s_data_q;
        if (w_out_fire) begin
            if (s_valid_q) begin
                o_data_d  = s_data_q;
                s_valid_d = 1'b0;
            end else begin
                o_valid_d = 1'b0;
            end
        end
        // in_ready is low while S is full, so an accept never races an S->O move.
        if (w_in_fire) begin
            if (!o_valid_q || out_ready_i) begin
                o_valid_d = 1'b1;
                o_data_d  = in_data_i;
            end else begin
                s_valid_d = 1'b1;
                s_data_d  = in_data_i;
            end
        end
        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
            s_valid_q  <= 1'b0;
            s_data_q   <= '0;
            in_ready_q <= 1'b1;
        end else begin
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = o_valid_q;
    assign out_data_o  = o_data_q;
endmodule : ext_skid_buffer
`default_nettype wire

// File: rtl/imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module : imm_extend_pipe
// Desc   : Pipelined sign/zero/upper/shl2 immediate extender; IMM_EXT_BYTE_EN
//          adds byte sign/zero modes.
// Rev    : 1.0  initial release
// ============================================================================
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  wire logic          Clk,
    input  wire logic          Reset,
    imm_extend_pipe_if.slave   bus
);
    if (IN_W < 8 || IN_W > 32) begin : g_bad_in_w
        $error("imm_extend_pipe: IN_W must be within 8..32");
    end
    if (OUT_W < 2 * IN_W) begin : g_bad_out_w
        $error("imm_extend_pipe: OUT_W must be at least 2*IN_W");
    end

    logic [OUT_W-1:0] w_sign;
    logic [OUT_W-1:0] w_zero;
    logic [OUT_W-1:0] w_ext_data;
    logic             w_ext_err;
    logic [OUT_W:0]   w_out_payload;

    assign w_sign = {{(OUT_W-IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
    assign w_zero = {{(OUT_W-IN_W){1'b0}}, bus.in_imm};

    always_comb begin
        w_ext_data = '0;
        w_ext_err  = 1'b0;
        case (bus.in_mode)
            MODE_SIGN:  w_ext_data = w_sign;
            MODE_ZERO:  w_ext_data = w_zero;
            MODE_UPPER: w_ext_data = w_zero << IN_W;
            MODE_SHL2:  w_ext_data = w_sign << 2;
`ifdef IMM_EXT_BYTE_EN
            MODE_SBYTE: w_ext_data = {{(OUT_W-8){bus.in_imm[7]}}, bus.in_imm[7:0]};
            MODE_ZBYTE: w_ext_data = {{(OUT_W-8){1'b0}}, bus.in_imm[7:0]};
`endif
            default:    w_ext_err  = 1'b1;
        endcase
    end

    ext_skid_buffer #(
        .W (OUT_W + 1)
    ) u_skid (
        .Clk         (Clk),
        .Reset       (Reset),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (bus.in_ready),
        .in_data_i   ({w_ext_err, w_ext_data}),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (w_out_payload)
    );

    assign bus.out_data = w_out_payload[OUT_W-1:0];
    assign bus.out_err  = w_out_payload[OUT_W];
endmodule : imm_extend_pipe
`default_nettype wire

// File: tb/tb_imm_extend_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_imm_extend_pipe
// Desc   : Scoreboard bench for imm_extend_pipe (IN_W=16, OUT_W=32).
// Rev    : 1.0  initial release
// ============================================================================
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int             n_cmp  = 0;
    int             n_fail = 0;
    bit             mon_en = 1'b0;
    bit             prev_stall = 1'b0;
    logic [OUT_W:0] prev_pay;
    logic [OUT_W:0] sb[$];

    function automatic logic [32:0] model(input logic [15:0] imm, input logic [2:0] mode);
        logic [31:0] s;
        s = 32'($signed(imm));
        case (mode)
            3'd0:    return {1'b0, s};
            3'd1:    return {1'b0, 16'h0000, imm};
            3'd2:    return {1'b0, imm, 16'h0000};
            3'd3:    return {1'b0, s[29:0], 2'b00};
`ifdef IMM_EXT_BYTE_EN
            3'd4:    return {1'b0, {24{imm[7]}}, imm[7:0]};
            3'd5:    return {1'b0, 24'h000000, imm[7:0]};
`endif
            default: return {1'b1, 32'h00000000};
        endcase
    endfunction

    // Occupancy model, stall stability and FIFO scoreboard, sampled mid-cycle.
    always @(negedge Clk) begin
        if (mon_en) begin
            n_cmp++;
            if (bus.out_valid !== (sb.size() != 0)) begin
                n_fail++;
                $display("FAIL occupancy: out_valid=%b expected %b", bus.out_valid, sb.size() != 0);
            end
            n_cmp++;
            if (bus.in_ready !== (sb.size() < 2)) begin
                n_fail++;
                $display("FAIL in_ready_vs_skid: in_ready=%b expected %b", bus.in_ready, sb.size() < 2);
            end
            if (prev_stall && bus.out_valid) begin
                n_cmp++;
                if ({bus.out_err, bus.out_data} !== prev_pay) begin
                    n_fail++;
                    $display("FAIL stall_stable: got %h expected %h", {bus.out_err, bus.out_data}, prev_pay);
                end
            end
            if (Reset) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (bus.in_valid && bus.in_ready)
                    sb.push_back(model(bus.in_imm, bus.in_mode));
                if (bus.out_valid && bus.out_ready) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL scoreboard_underflow: got %h expected none", {bus.out_err, bus.out_data});
                    end else begin
                        logic [OUT_W:0] exp_pay;
                        exp_pay = sb.pop_front();
                        if ({bus.out_err, bus.out_data} !== exp_pay) begin
                            n_fail++;
                            $display("FAIL scoreboard: got %h expected %h", {bus.out_err, bus.out_data}, exp_pay);
                        end
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_pay   = {bus.out_err, bus.out_data};
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'h1234;
        bus.in_mode   = MODE_SIGN;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
            n_cmp++;
            if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
            n_cmp++;
            if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        end
        bus.in_valid = 1'b0;
        Reset  = 1'b0;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_modes();
        logic [15:0] imms [5] = '{16'h8004, 16'h8004, 16'h8004, 16'h8004, 16'h7FFF};
        logic [2:0]  modes[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        logic [31:0] exps [5] = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010, 32'h00007FFF};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = imms[i];
            bus.in_mode  = modes[i];
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exps[i] || bus.out_err !== 1'b0) begin
                n_fail++;
                $display("FAIL mode_%0d: got v=%b d=%h e=%b expected v=1 d=%h e=0",
                         i, bus.out_valid, bus.out_data, bus.out_err, exps[i]);
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_imm = 16'h0011; bus.in_mode = MODE_SIGN;
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_a: in_ready %b expected 1", bus.in_ready); end
        bus.in_imm = 16'h8001; bus.in_mode = MODE_ZERO;
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 32'h00000011) begin
            n_fail++; $display("FAIL bp_after_b: in_ready %b data %h expected 0 / 00000011", bus.in_ready, bus.out_data);
        end
        bus.in_imm = 16'h00FF; bus.in_mode = MODE_UPPER;
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_data !== 32'h00000011) begin
            n_fail++; $display("FAIL bp_hold_c: in_ready %b data %h expected 0 / 00000011", bus.in_ready, bus.out_data);
        end
        bus.out_ready = 1'b1;
        tick();
        n_cmp++;
        if (bus.in_ready !== 1'b1 || bus.out_data !== 32'h00008001) begin
            n_fail++; $display("FAIL bp_release_b: in_ready %b data %h expected 1 / 00008001", bus.in_ready, bus.out_data);
        end
        tick();
        bus.in_valid = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00FF0000) begin
            n_fail++; $display("FAIL bp_release_c: valid %b data %h expected 1 / 00FF0000", bus.out_valid, bus.out_data);
        end
        tick();
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: out_valid %b expected 0", bus.out_valid); end
    endtask

    task automatic test_streaming();
        int  acc = 0;
        int  cyc = 0;
        bit  fire;
        bus.in_imm  = 16'($urandom);
        bus.in_mode = 3'($urandom_range(0, 7));
        while (acc < 100 && cyc < 5000) begin
            bus.in_valid  = ($urandom_range(0, 4) != 0);
            bus.out_ready = $urandom_range(0, 1) == 1;
            fire = bus.in_valid && bus.in_ready;
            tick();
            cyc++;
            if (fire) begin
                acc++;
                bus.in_imm  = 16'($urandom);
                bus.in_mode = 3'($urandom_range(0, 7));
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++;
        if (acc != 100) begin n_fail++; $display("FAIL stream_accept: accepted %0d expected 100", acc); end
        for (int i = 0; i < 10 && sb.size() != 0; i++) tick();
        tick();
        n_cmp++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL stream_drain: %0d left expected 0", sb.size()); end
    endtask

    task automatic test_byte_modes();
        logic [2:0]  modes[3] = '{3'd4, 3'd5, 3'd7};
`ifdef IMM_EXT_BYTE_EN
        logic [32:0] exps[3]  = '{{1'b0, 32'hFFFFFF80}, {1'b0, 32'h00000080}, {1'b1, 32'h0}};
`else
        logic [32:0] exps[3]  = '{{1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0}};
`endif
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = 16'h1280;
            bus.in_mode  = modes[i];
            tick();
            n_cmp++;
            if (bus.out_valid !== 1'b1 || {bus.out_err, bus.out_data} !== exps[i]) begin
                n_fail++;
                $display("FAIL byte_mode_%0d: got v=%b e=%b d=%h expected v=1 e/d=%h",
                         modes[i], bus.out_valid, bus.out_err, bus.out_data, exps[i]);
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstall();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = MODE_SIGN;
        bus.in_imm    = 16'h5555;
        tick();
        bus.in_imm    = 16'hAAAA;
        tick();
        bus.in_valid  = 1'b0;
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL midstall_full: in_ready %b out_valid %b expected 0 / 1", bus.in_ready, bus.out_valid);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midstall_reset: out_valid %b in_ready %b expected 0 / 1", bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_imm    = 16'h0001;
        bus.in_mode   = MODE_SIGN;
        tick();
        bus.in_valid  = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h00000001 || bus.out_err !== 1'b0) begin
            n_fail++; $display("FAIL midstall_fresh: v=%b d=%h e=%b expected 1 / 00000001 / 0",
                               bus.out_valid, bus.out_data, bus.out_err);
        end
        tick();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_modes();
        test_backpressure();
        test_streaming();
        test_byte_modes();
        test_reset_midstall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule : tb_imm_extend_pipe
`default_nettype wire
